// File: rtl/wb_stage_if.sv
// Memory-stage -> write-back handshake bundle: one retiring instruction plus its
// operands, qualified by valid_last/ready_last.
interface wb_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) ();
    logic             valid_last;
    logic             ready_last;
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [RF_AW-1:0] rd;
    logic             R_wen;
    logic             mem_ren;
    logic [XLEN-1:0]  MEM_Rdata;
    logic [XLEN-1:0]  Ex_result;
    logic [XLEN-1:0]  csrs;
    logic [3:0]       csr_wen;
    logic             jump_flag;

    modport master (
        output valid_last, pc, inst, rd, R_wen, mem_ren, MEM_Rdata,
               Ex_result, csrs, csr_wen, jump_flag,
        input  ready_last
    );

    modport slave (
        input  valid_last, pc, inst, rd, R_wen, mem_ren, MEM_Rdata,
               Ex_result, csrs, csr_wen, jump_flag,
        output ready_last
    );
endinterface

// File: rtl/wb_stage.sv
// RV32 write-back stage: GPR/CSR write ports, EX forwarding, difftest commit record
// and minstret. All outputs are registers loaded from the next-state decode.
module wb_stage #(
    parameter int unsigned      XLEN         = 32,
    parameter int unsigned      RF_AW        = 5,
    parameter int unsigned      CNT_W        = 64,
    parameter logic [CNT_W-1:0] MINSTRET_RST = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        up,
    output logic             rf_wen,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             csr_we,
    output logic [11:0]      csr_waddr,
    output logic [XLEN-1:0]  csr_wdata,
    output logic             fwd_valid,
    output logic [RF_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic [31:0]      commit_inst,
    output logic             commit_jump,
    output logic [CNT_W-1:0] minstret
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RETIRE = 2'd1,
        S_ECALL2 = 2'd2
    } state_e;

    localparam logic [11:0]     CSR_MSTATUS    = 12'h300;
    localparam logic [11:0]     CSR_MEPC       = 12'h341;
    localparam logic [11:0]     CSR_MCAUSE     = 12'h342;
    localparam logic [XLEN-1:0] MCAUSE_ECALL_M = {{(XLEN-4){1'b0}}, 4'd11};

    state_e           state_r, state_s;
    logic             ready_r, ready_s;
    logic             accept_s;

    logic [XLEN-1:0]  pc_r, pc_s;
    logic [31:0]      inst_r, inst_s;
    logic [RF_AW-1:0] rd_r, rd_s;
    logic             r_wen_r, r_wen_s;
    logic             mem_ren_r, mem_ren_s;
    logic [XLEN-1:0]  mem_rdata_r, mem_rdata_s;
    logic [XLEN-1:0]  ex_result_r, ex_result_s;
    logic [XLEN-1:0]  csrs_r, csrs_s;
    logic [2:0]       csr_wen_r, csr_wen_s;
    logic             jump_r, jump_s;

    logic             rf_wen_s;
    logic [RF_AW-1:0] rf_waddr_s;
    logic [XLEN-1:0]  rf_wdata_s;
    logic             csr_we_s;
    logic [11:0]      csr_waddr_s;
    logic [XLEN-1:0]  csr_wdata_s;
    logic             commit_valid_s;
    logic [XLEN-1:0]  commit_pc_s;
    logic [31:0]      commit_inst_s;
    logic             commit_jump_s;

    // csr_wen[3] is reserved and deliberately never captured
    logic             csr_wen_rsvd_unused_s;
    assign csr_wen_rsvd_unused_s = up.csr_wen[3];

    assign accept_s      = up.valid_last & ready_r;
    assign up.ready_last = ready_r;

    assign fwd_valid = rf_wen;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

    // Payload seen by the next cycle: fresh inputs on accept, otherwise the held copy
    always_comb begin
        if (accept_s) begin
            pc_s        = up.pc;
            inst_s      = up.inst;
            rd_s        = up.rd;
            r_wen_s     = up.R_wen;
            mem_ren_s   = up.mem_ren;
            mem_rdata_s = up.MEM_Rdata;
            ex_result_s = up.Ex_result;
            csrs_s      = up.csrs;
            csr_wen_s   = up.csr_wen[2:0];
            jump_s      = up.jump_flag;
        end else begin
            pc_s        = pc_r;
            inst_s      = inst_r;
            rd_s        = rd_r;
            r_wen_s     = r_wen_r;
            mem_ren_s   = mem_ren_r;
            mem_rdata_s = mem_rdata_r;
            ex_result_s = ex_result_r;
            csrs_s      = csrs_r;
            csr_wen_s   = csr_wen_r;
            jump_s      = jump_r;
        end
    end

    // Next-state logic; an ecall in RETIRE always moves on to its mcause cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_s = S_RETIRE;
                else          state_s = S_IDLE;
            end
            S_RETIRE: begin
                if (csr_wen_r[2])  state_s = S_ECALL2;
                else if (accept_s) state_s = S_RETIRE;
                else               state_s = S_IDLE;
            end
            S_ECALL2: begin
                if (accept_s) state_s = S_RETIRE;
                else          state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode for the upcoming cycle, driven from next state and next payload
    always_comb begin
        ready_s        = 1'b1;
        rf_wen_s       = 1'b0;
        rf_waddr_s     = {RF_AW{1'b0}};
        rf_wdata_s     = {XLEN{1'b0}};
        csr_we_s       = 1'b0;
        csr_waddr_s    = 12'h000;
        csr_wdata_s    = {XLEN{1'b0}};
        commit_valid_s = 1'b0;
        commit_pc_s    = {XLEN{1'b0}};
        commit_inst_s  = 32'h0000_0000;
        commit_jump_s  = 1'b0;
        case (state_s)
            S_RETIRE: begin
                rf_wen_s   = r_wen_s & (rd_s != {RF_AW{1'b0}});
                rf_waddr_s = rd_s;
                if (mem_ren_s)         rf_wdata_s = mem_rdata_s;
                else if (csr_wen_s[0]) rf_wdata_s = csrs_s;
                else                   rf_wdata_s = ex_result_s;
                if (csr_wen_s[2]) begin
                    // ecall: mepc now, mcause and commit follow in ECALL2
                    ready_s     = 1'b0;
                    csr_we_s    = 1'b1;
                    csr_waddr_s = CSR_MEPC;
                    csr_wdata_s = pc_s;
                end else begin
                    commit_valid_s = 1'b1;
                    commit_pc_s    = pc_s;
                    commit_inst_s  = inst_s;
                    commit_jump_s  = jump_s;
                    if (csr_wen_s[1]) begin
                        csr_we_s    = 1'b1;
                        csr_waddr_s = CSR_MSTATUS;
                        csr_wdata_s = ex_result_s;
                    end else if (csr_wen_s[0]) begin
                        csr_we_s    = 1'b1;
                        csr_waddr_s = inst_s[31:20];
                        csr_wdata_s = ex_result_s;
                    end else begin
                        csr_we_s    = 1'b0;
                    end
                end
            end
            S_ECALL2: begin
                csr_we_s       = 1'b1;
                csr_waddr_s    = CSR_MCAUSE;
                csr_wdata_s    = MCAUSE_ECALL_M;
                commit_valid_s = 1'b1;
                commit_pc_s    = pc_s;
                commit_inst_s  = inst_s;
                commit_jump_s  = jump_s;
            end
            default: begin
                ready_s = 1'b1;
            end
        endcase
    end

    // State, payload and output registers; reset drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            ready_r      <= 1'b1;
            pc_r         <= {XLEN{1'b0}};
            inst_r       <= 32'h0000_0000;
            rd_r         <= {RF_AW{1'b0}};
            r_wen_r      <= 1'b0;
            mem_ren_r    <= 1'b0;
            mem_rdata_r  <= {XLEN{1'b0}};
            ex_result_r  <= {XLEN{1'b0}};
            csrs_r       <= {XLEN{1'b0}};
            csr_wen_r    <= 3'b000;
            jump_r       <= 1'b0;
            rf_wen       <= 1'b0;
            rf_waddr     <= {RF_AW{1'b0}};
            rf_wdata     <= {XLEN{1'b0}};
            csr_we       <= 1'b0;
            csr_waddr    <= 12'h000;
            csr_wdata    <= {XLEN{1'b0}};
            commit_valid <= 1'b0;
            commit_pc    <= {XLEN{1'b0}};
            commit_inst  <= 32'h0000_0000;
            commit_jump  <= 1'b0;
        end else begin
            state_r      <= state_s;
            ready_r      <= ready_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            rd_r         <= rd_s;
            r_wen_r      <= r_wen_s;
            mem_ren_r    <= mem_ren_s;
            mem_rdata_r  <= mem_rdata_s;
            ex_result_r  <= ex_result_s;
            csrs_r       <= csrs_s;
            csr_wen_r    <= csr_wen_s;
            jump_r       <= jump_s;
            rf_wen       <= rf_wen_s;
            rf_waddr     <= rf_waddr_s;
            rf_wdata     <= rf_wdata_s;
            csr_we       <= csr_we_s;
            csr_waddr    <= csr_waddr_s;
            csr_wdata    <= csr_wdata_s;
            commit_valid <= commit_valid_s;
            commit_pc    <= commit_pc_s;
            commit_inst  <= commit_inst_s;
            commit_jump  <= commit_jump_s;
        end
    end

    // minstret counts a retirement at the end of its commit cycle and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret <= MINSTRET_RST;
        end else begin
            minstret <= minstret + {{(CNT_W-1){1'b0}}, commit_valid};
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors checked with immediate assertions.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wb_stage_if #(.XLEN(32), .RF_AW(5)) bus  ();
    wb_stage_if #(.XLEN(32), .RF_AW(5)) bus2 ();

    logic        rf_wen, csr_we, fwd_valid, commit_valid, commit_jump;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, csr_wdata, fwd_data, commit_pc, commit_inst;
    logic [11:0] csr_waddr;
    logic [63:0] minstret;

    logic        d2_rf_wen, d2_csr_we, d2_fwd_valid, d2_commit_valid, d2_commit_jump;
    logic [4:0]  d2_rf_waddr, d2_fwd_rd;
    logic [31:0] d2_rf_wdata, d2_csr_wdata, d2_fwd_data, d2_commit_pc, d2_commit_inst;
    logic [11:0] d2_csr_waddr;
    logic [63:0] d2_minstret;

    wb_stage dut (
        .clk(clk), .rst(rst), .up(bus),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_jump(commit_jump), .minstret(minstret)
    );

    wb_stage #(.MINSTRET_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst), .up(bus2),
        .rf_wen(d2_rf_wen), .rf_waddr(d2_rf_waddr), .rf_wdata(d2_rf_wdata),
        .csr_we(d2_csr_we), .csr_waddr(d2_csr_waddr), .csr_wdata(d2_csr_wdata),
        .fwd_valid(d2_fwd_valid), .fwd_rd(d2_fwd_rd), .fwd_data(d2_fwd_data),
        .commit_valid(d2_commit_valid), .commit_pc(d2_commit_pc), .commit_inst(d2_commit_inst),
        .commit_jump(d2_commit_jump), .minstret(d2_minstret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                         input logic rwen, input logic memren, input logic [31:0] mrdata,
                         input logic [31:0] ex, input logic [31:0] csrs, input logic [3:0] cwen,
                         input logic jump);
        bus.valid_last = 1'b1;
        bus.pc         = pc;
        bus.inst       = inst;
        bus.rd         = rd;
        bus.R_wen      = rwen;
        bus.mem_ren    = memren;
        bus.MEM_Rdata  = mrdata;
        bus.Ex_result  = ex;
        bus.csrs       = csrs;
        bus.csr_wen    = cwen;
        bus.jump_flag  = jump;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
        bus.valid_last = 1'b0;
        bus2.valid_last = 1'b0; bus2.pc = 32'h0000_0040; bus2.inst = 32'h0000_0013;
        bus2.rd = 5'd0; bus2.R_wen = 1'b0; bus2.mem_ren = 1'b0; bus2.MEM_Rdata = 32'h0;
        bus2.Ex_result = 32'h0; bus2.csrs = 32'h0; bus2.csr_wen = 4'b0000; bus2.jump_flag = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_ready", bus.ready_last, 1'b1);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_csr_we", csr_we, 1'b0);
        chk("rst_commit", commit_valid, 1'b0);
        chk("rst_commit_pc", commit_pc, 32'h0);
        chk("rst_minstret", minstret, 64'h0);
        chk("rst_minstret_preload", d2_minstret, 64'hFFFF_FFFF_FFFF_FFFF);

        // preloaded minstret wraps on one commit
        bus2.valid_last = 1'b1;
        tick();
        bus2.valid_last = 1'b0;
        chk("wrap_commit", d2_commit_valid, 1'b1);
        chk("wrap_before", d2_minstret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wrap_after", d2_minstret, 64'h0);
        chk("idle_minstret", minstret, 64'h0);

        // lw x5
        drive(32'h8000_0000, 32'h0000_A283, 5'd5, 1'b1, 1'b1, 32'hFFFF_FF80, 32'h0000_1000, 32'h0, 4'b0000, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("lw_rf_wen", rf_wen, 1'b1);
        chk("lw_waddr", rf_waddr, 5'd5);
        chk("lw_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lw_fwd_valid", fwd_valid, 1'b1);
        chk("lw_fwd_data", fwd_data, 32'hFFFF_FF80);
        chk("lw_commit", commit_valid, 1'b1);
        chk("lw_commit_pc", commit_pc, 32'h8000_0000);
        chk("lw_commit_inst", commit_inst, 32'h0000_A283);
        chk("lw_minstret_during", minstret, 64'd0);
        tick();
        chk("lw_commit_drop", commit_valid, 1'b0);
        chk("lw_rf_wen_drop", rf_wen, 1'b0);
        chk("lw_commit_pc_idle", commit_pc, 32'h0);
        chk("lw_minstret_after", minstret, 64'd1);

        // addi x0 never writes the register file
        drive(32'h8000_0004, 32'h2340_0013, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 32'h0, 4'b0000, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("x0_rf_wen", rf_wen, 1'b0);
        chk("x0_fwd_valid", fwd_valid, 1'b0);
        chk("x0_commit", commit_valid, 1'b1);
        chk("x0_commit_pc", commit_pc, 32'h8000_0004);
        tick();
        chk("x0_minstret", minstret, 64'd2);

        // ecall, with the next instruction waiting during the stall cycle
        drive(32'h8000_0010, 32'h0000_0073, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0100, 1'b0);
        tick();
        chk("ecall1_csr_we", csr_we, 1'b1);
        chk("ecall1_addr", csr_waddr, 12'h341);
        chk("ecall1_data", csr_wdata, 32'h8000_0010);
        chk("ecall1_ready", bus.ready_last, 1'b0);
        chk("ecall1_commit", commit_valid, 1'b0);
        drive(32'h8000_0100, 32'h0770_0493, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0000_0077, 32'h0, 4'b0000, 1'b0);
        tick();
        chk("ecall2_csr_we", csr_we, 1'b1);
        chk("ecall2_addr", csr_waddr, 12'h342);
        chk("ecall2_data", csr_wdata, 32'd11);
        chk("ecall2_commit", commit_valid, 1'b1);
        chk("ecall2_commit_pc", commit_pc, 32'h8000_0010);
        chk("ecall2_commit_inst", commit_inst, 32'h0000_0073);
        chk("ecall2_rf_wen", rf_wen, 1'b0);
        chk("ecall2_ready", bus.ready_last, 1'b1);
        tick();
        bus.valid_last = 1'b0;
        chk("post_ecall_rf_wen", rf_wen, 1'b1);
        chk("post_ecall_waddr", rf_waddr, 5'd9);
        chk("post_ecall_wdata", rf_wdata, 32'h77);
        chk("post_ecall_pc", commit_pc, 32'h8000_0100);
        chk("post_ecall_csr_we", csr_we, 1'b0);
        chk("post_ecall_minstret", minstret, 64'd3);
        tick();
        chk("pre_burst_minstret", minstret, 64'd4);

        // three back-to-back ALU ops
        drive(32'h0000_0200, 32'h0110_0093, 5'd1, 1'b1, 1'b0, 32'h0, 32'h11, 32'h0, 4'b0000, 1'b0);
        tick();
        chk("burst_a_commit", commit_valid, 1'b1);
        chk("burst_a_waddr", rf_waddr, 5'd1);
        drive(32'h0000_0204, 32'h0220_0113, 5'd2, 1'b1, 1'b0, 32'h0, 32'h22, 32'h0, 4'b0000, 1'b1);
        tick();
        chk("burst_b_commit", commit_valid, 1'b1);
        chk("burst_b_pc", commit_pc, 32'h204);
        chk("burst_b_jump", commit_jump, 1'b1);
        chk("burst_b_wdata", rf_wdata, 32'h22);
        chk("burst_b_minstret", minstret, 64'd5);
        drive(32'h0000_0208, 32'h0330_0193, 5'd3, 1'b1, 1'b0, 32'h0, 32'h33, 32'h0, 4'b0000, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("burst_c_commit", commit_valid, 1'b1);
        chk("burst_c_pc", commit_pc, 32'h208);
        chk("burst_c_jump", commit_jump, 1'b0);
        chk("burst_c_minstret", minstret, 64'd6);
        tick();
        chk("burst_end_commit", commit_valid, 1'b0);
        chk("burst_end_minstret", minstret, 64'd7);

        // csrrw x7, mtvec: old value to rd, new value to the CSR in the same cycle
        drive(32'h0000_020C, 32'h3050_93F3, 5'd7, 1'b1, 1'b0, 32'h0, 32'h5, 32'hA, 4'b0001, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("csrrw_rf_wen", rf_wen, 1'b1);
        chk("csrrw_waddr", rf_waddr, 5'd7);
        chk("csrrw_wdata", rf_wdata, 32'hA);
        chk("csrrw_csr_we", csr_we, 1'b1);
        chk("csrrw_csr_addr", csr_waddr, 12'h305);
        chk("csrrw_csr_data", csr_wdata, 32'h5);
        tick();
        chk("csrrw_csr_we_drop", csr_we, 1'b0);

        // mret beats csr op; reserved bit ignored
        drive(32'h0000_0210, 32'h3020_0073, 5'd0, 1'b0, 1'b0, 32'h0, 32'h1888, 32'h0, 4'b1011, 1'b1);
        tick();
        bus.valid_last = 1'b0;
        chk("mret_csr_we", csr_we, 1'b1);
        chk("mret_addr", csr_waddr, 12'h300);
        chk("mret_data", csr_wdata, 32'h1888);
        chk("mret_jump", commit_jump, 1'b1);
        tick();
        chk("mret_minstret", minstret, 64'd9);

        // reset lands where ECALL2 would have been
        drive(32'h8000_0020, 32'h0000_0073, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0100, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("rstec_mepc", csr_waddr, 12'h341);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstec_csr_we", csr_we, 1'b0);
        chk("rstec_csr_addr", csr_waddr, 12'h000);
        chk("rstec_commit", commit_valid, 1'b0);
        chk("rstec_minstret", minstret, 64'd0);
        chk("rstec_ready", bus.ready_last, 1'b1);
        tick();
        chk("rstec_no_late_we", csr_we, 1'b0);
        chk("rstec_no_late_commit", commit_valid, 1'b0);
        drive(32'h0000_0300, 32'h0440_0213, 5'd4, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 4'b0000, 1'b0);
        tick();
        bus.valid_last = 1'b0;
        chk("rstec_next_commit", commit_valid, 1'b1);
        chk("rstec_next_wdata", rf_wdata, 32'h44);
        tick();
        chk("rstec_next_minstret", minstret, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
